// File: rtl/mcu0_intc_pkg.sv
// mcu0_intc_pkg: shared state encoding, register map and STAT layout for the interrupt controller
package mcu0_intc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;
  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_CLR  = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;
  localparam int STAT_ST_LSB = 4;
  localparam int STAT_ID_LSB = 0;
endpackage

// File: rtl/mcu0_intc_if.sv
// mcu0_intc_if: sources, core handshake and register port of the interrupt controller
interface mcu0_intc_if #(parameter int NSRC = 8, parameter int DW = 16);
  logic [NSRC-1:0] src;
  logic iack;
  logic eoi;
  logic reg_we;
  logic [1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic interrupt;
  logic [2:0] irq;
  modport master (output src, iack, eoi, reg_we, reg_addr, reg_wdata, input reg_rdata, interrupt, irq);
  modport slave (input src, iack, eoi, reg_we, reg_addr, reg_wdata, output reg_rdata, interrupt, irq);
endinterface

// File: rtl/mcu0_intc_prio.sv
// mcu0_intc_prio: lowest-index-wins priority encoder with valid flag
module mcu0_intc_prio #(parameter int N = 8) (
  input  logic [N-1:0] req,
  output logic [2:0]   id,
  output logic         valid
);
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) id = 3'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/mcu0_intc.sv
// mcu0_intc: fixed-priority interrupt controller with mask, pending latch and iack/eoi handshake
module mcu0_intc import mcu0_intc_pkg::*; #(
  parameter int NSRC = 8,
  parameter int DW = 16,
  parameter logic [7:0] EDGE_MASK = 8'hFF
) (
  input logic clock,
  input logic reset,
  mcu0_intc_if.slave bus
);
  logic [NSRC-1:0] pending, mask, src_q, eligible, wvec, edge_m, set_vec, clr_vec;
  logic [2:0] active_id, best;
  logic best_v, wr_mask, wr_pend, wr_clr, take, unused_wdata;
  state_t state, state_n;
  assign wvec = bus.reg_wdata[NSRC-1:0];
  assign unused_wdata = ^bus.reg_wdata;
  assign edge_m = EDGE_MASK[NSRC-1:0];
  assign wr_mask = bus.reg_we && bus.reg_addr == A_MASK;
  assign wr_pend = bus.reg_we && bus.reg_addr == A_PEND;
  assign wr_clr = bus.reg_we && bus.reg_addr == A_CLR;
  assign take = state == REQ && bus.iack;
  assign eligible = pending & mask;
  // Sets are OR-ed in after clears so a coincident event is never lost.
  assign set_vec = (bus.src & ~src_q & edge_m) | (bus.src & ~edge_m) | (wr_pend ? wvec : '0);
  assign clr_vec = (wr_clr ? wvec : '0) | (take ? NSRC'(1) << active_id : '0);
  mcu0_intc_prio #(.N(NSRC)) u_prio (.req(eligible), .id(best), .valid(best_v));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      mask <= '0;
      src_q <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      mask <= wr_mask ? wvec : mask;
      src_q <= bus.src;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      active_id <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && best_v) active_id <= best;
    end
  end
  // iack beats a same-cycle withdrawal: the core has already jumped.
  always_comb begin
    state_n = state == IDLE ? (best_v ? REQ : IDLE)
            : state == REQ  ? (bus.iack ? SERV : (pending[active_id] && mask[active_id]) ? REQ : IDLE)
            : state == SERV ? (bus.eoi ? IDLE : SERV)
            : IDLE;
  end
  always_comb begin
    bus.interrupt = state == REQ;
    bus.irq = active_id;
    bus.reg_rdata = bus.reg_addr == A_MASK ? DW'(mask)
                  : bus.reg_addr == A_PEND ? DW'(pending)
                  : bus.reg_addr == A_STAT ? (DW'(state) << STAT_ST_LSB) | (DW'(active_id) << STAT_ID_LSB)
                  : '0;
  end
endmodule

// File: tb/tb_mcu0_intc.sv
// tb_mcu0_intc: directed table and sequence checks for mcu0_intc (source 0 level, others edge)
module tb_mcu0_intc;
  import mcu0_intc_pkg::*;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0;
  mcu0_intc_if #(.NSRC(8), .DW(16)) ifc ();
  mcu0_intc #(.NSRC(8), .DW(16), .EDGE_MASK(8'hFE)) dut (.clock(clk), .reset(rst), .bus(ifc.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic we;
    logic [1:0] addr;
    logic [15:0] wdata;
    logic [1:0] raddr;
    logic [15:0] exp;
  } vec_t;
  vec_t tab[9];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic rdchk(string nm, logic [1:0] a, logic [15:0] exp);
    ifc.reg_addr = a;
    #1;
    chk(nm, ifc.reg_rdata, exp);
  endtask
  task automatic wr(logic [1:0] a, logic [15:0] d);
    ifc.reg_we = 1;
    ifc.reg_addr = a;
    ifc.reg_wdata = d;
    tick();
    ifc.reg_we = 0;
  endtask
  task automatic pulse_src(logic [7:0] s);
    ifc.src = s;
    tick();
    ifc.src = '0;
  endtask
  task automatic ack();
    ifc.iack = 1;
    tick();
    ifc.iack = 0;
  endtask
  task automatic end_irq();
    ifc.eoi = 1;
    tick();
    ifc.eoi = 0;
  endtask
  initial begin
    tab[0] = '{0, A_MASK, 16'h0000, A_MASK, 16'h0000};
    tab[1] = '{0, A_MASK, 16'h0000, A_PEND, 16'h0000};
    tab[2] = '{0, A_MASK, 16'h0000, A_STAT, 16'h0000};
    tab[3] = '{1, A_MASK, 16'hFFA5, A_MASK, 16'h00A5};
    tab[4] = '{1, A_PEND, 16'h0012, A_PEND, 16'h0012};
    tab[5] = '{1, A_CLR,  16'h0002, A_PEND, 16'h0010};
    tab[6] = '{0, A_MASK, 16'h0000, A_CLR,  16'h0000};
    tab[7] = '{1, A_CLR,  16'hFFFF, A_PEND, 16'h0000};
    tab[8] = '{1, A_MASK, 16'h0000, A_MASK, 16'h0000};
    ifc.src = '0; ifc.iack = 0; ifc.eoi = 0;
    ifc.reg_we = 0; ifc.reg_addr = '0; ifc.reg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_int", 16'(ifc.interrupt), 16'h0);
    chk("reset_irq", 16'(ifc.irq), 16'h0);
    rst = 0;
    tick();
    for (int i = 0; i < 9; i++) begin
      ifc.reg_we = tab[i].we;
      ifc.reg_addr = tab[i].addr;
      ifc.reg_wdata = tab[i].wdata;
      tick();
      ifc.reg_we = 0;
      rdchk($sformatf("tab%0d", i), tab[i].raddr, tab[i].exp);
      chk($sformatf("tab%0d_int", i), 16'(ifc.interrupt), 16'h0);
    end
    // basic request on edge source 2
    wr(A_MASK, 16'h0004);
    pulse_src(8'h04);
    chk("basic_int_k", 16'(ifc.interrupt), 16'h0);
    tick();
    chk("basic_int", 16'(ifc.interrupt), 16'h1);
    chk("basic_irq", 16'(ifc.irq), 16'h2);
    rdchk("basic_pend", A_PEND, 16'h0004);
    ack();
    chk("basic_ack_int", 16'(ifc.interrupt), 16'h0);
    rdchk("basic_ack_pend", A_PEND, 16'h0000);
    rdchk("basic_serv_stat", A_STAT, 16'h0022);
    end_irq();
    rdchk("basic_eoi_stat", A_STAT, 16'h0002);
    // priority: 1 beats 5, 5 follows after eoi
    wr(A_MASK, 16'h00FF);
    pulse_src(8'h22);
    tick();
    chk("prio_int", 16'(ifc.interrupt), 16'h1);
    chk("prio_irq", 16'(ifc.irq), 16'h1);
    ack();
    chk("prio_ack_int", 16'(ifc.interrupt), 16'h0);
    rdchk("prio_pend", A_PEND, 16'h0020);
    end_irq();
    chk("prio_eoi_int", 16'(ifc.interrupt), 16'h0);
    tick();
    chk("prio2_int", 16'(ifc.interrupt), 16'h1);
    chk("prio2_irq", 16'(ifc.irq), 16'h5);
    ack();
    end_irq();
    // mask withdraw before iack
    wr(A_MASK, 16'h0008);
    pulse_src(8'h08);
    tick();
    chk("wd_int", 16'(ifc.interrupt), 16'h1);
    chk("wd_irq", 16'(ifc.irq), 16'h3);
    wr(A_MASK, 16'h0000);
    tick();
    chk("wd_drop_int", 16'(ifc.interrupt), 16'h0);
    rdchk("wd_pend", A_PEND, 16'h0008);
    wr(A_MASK, 16'h0008);
    tick();
    chk("wd_re_int", 16'(ifc.interrupt), 16'h1);
    chk("wd_re_irq", 16'(ifc.irq), 16'h3);
    ack();
    end_irq();
    // set beats clear in the same cycle
    wr(A_MASK, 16'h0000);
    ifc.src = 8'h10;
    ifc.reg_we = 1; ifc.reg_addr = A_CLR; ifc.reg_wdata = 16'h0010;
    tick();
    ifc.reg_we = 0; ifc.src = '0;
    rdchk("setclr_pend", A_PEND, 16'h0010);
    wr(A_CLR, 16'h0010);
    wr(A_MASK, 16'h0014);
    pulse_src(8'h04);
    tick();
    chk("serv_irq2", 16'(ifc.irq), 16'h2);
    ack();
    pulse_src(8'h10);
    chk("serv_int", 16'(ifc.interrupt), 16'h0);
    rdchk("serv_pend", A_PEND, 16'h0010);
    rdchk("serv_stat", A_STAT, 16'h0022);
    end_irq();
    tick();
    chk("serv_after_int", 16'(ifc.interrupt), 16'h1);
    chk("serv_after_irq", 16'(ifc.irq), 16'h4);
    ack();
    end_irq();
    // level source 0
    wr(A_MASK, 16'h0000);
    ifc.src = 8'h01;
    tick();
    wr(A_CLR, 16'h0001);
    rdchk("lvl_held_pend", A_PEND, 16'h0001);
    ifc.src = '0;
    tick();
    wr(A_CLR, 16'h0001);
    rdchk("lvl_clr_pend", A_PEND, 16'h0000);
    wr(A_MASK, 16'h0040);
    wr(A_PEND, 16'h0040);
    tick();
    chk("sw_int", 16'(ifc.interrupt), 16'h1);
    chk("sw_irq", 16'(ifc.irq), 16'h6);
    ack();
    rdchk("sw_serv_stat", A_STAT, 16'h0026);
    // asynchronous reset mid-service
    #2;
    rst = 1;
    #1;
    chk("arst_int", 16'(ifc.interrupt), 16'h0);
    chk("arst_irq", 16'(ifc.irq), 16'h0);
    rst = 0;
    end_irq();
    rdchk("arst_stat", A_STAT, 16'h0000);
    rdchk("arst_mask", A_MASK, 16'h0000);
    chk("arst_eoi_int", 16'(ifc.interrupt), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcu0_intc.md
Name: mcu0_intc

Overview:
- Fixed-priority interrupt controller that sits directly upstream of the mcu0 core.
- It collects up to 8 peripheral interrupt sources and latches them as pending.
- It applies a software mask and presents one request to the core on the core's `interrupt` / `irq[2:0]` inputs.
- It holds that request under an acknowledge / end-of-interrupt handshake. The core reads and writes its registers through a small word-wide register port.

Parameters:
- NSRC, 8, number of interrupt sources (1..8; irq is 3 bits).
- DW, 16, register data width (matches the mcu0 word).
- EDGE_MASK, 8'hFF, per source: 1 = rising-edge triggered, 0 = level triggered.

Ports:
- clock  in  1  system clock, posedge active.
- reset  in  1  asynchronous, active-high reset.
- src  in  NSRC  interrupt sources, synchronous to clock.
- iack  in  1  one-cycle pulse: the core has taken the interrupt (set I, loaded LR, jumped).
- eoi  in  1  one-cycle pulse: the core executed IRET.
- reg_we  in  1  register write strobe.
- reg_addr  in  2  register select.
- reg_wdata  in  DW  write data.
- reg_rdata  out  DW  read data, combinational from the registers.
- interrupt  out  1  request to the core.
- irq  out  3  vector of the request; it is also the core's jump target.

Behaviour:
- Reset: all of the following are 0 — pending, mask, src_q, active_id, state=IDLE, interrupt, irq. Reset mid-service discards everything; no eoi is required afterwards.
- Registers, selected by reg_addr:
  - 0 MASK: RW. Bit i=1 enables source i.
  - 1 PEND: read gives pending. A write sets pending |= wdata (software trigger).
  - 2 CLR: write-1-to-clear of pending. Reads return 0.
  - 3 STAT: read-only: {state[1:0] at [5:4], active_id at [2:0]}. Other bits read 0.
  - Bits at or above NSRC read 0 and ignore writes.
- Source capture:
  - src_q <= src every cycle.
  - Edge source i: pending[i] is set on the posedge where src[i]=1 and src_q[i]=0.
  - Level source i: pending[i] is set on every posedge with src[i]=1. A CLR of that bit only takes effect once src[i] is low.
  - If a set and a clear hit the same bit in the same cycle, the set wins (no event is lost).
- Candidate: eligible = pending & mask. best = the lowest index set in eligible (bit 0 has highest priority).
- States (2-bit encoding: IDLE=0, REQ=1, SERV=2):
  - IDLE: if eligible is non-zero, go to REQ. Latch active_id=best, set irq=best, set interrupt=1.
  - REQ: interrupt stays 1 and irq stays frozen. A higher-priority arrival does NOT preempt.
    - If pending[active_id] or mask[active_id] drops before iack: interrupt=0 and go to IDLE on the next edge. Re-arbitration happens from IDLE.
    - On iack: clear pending[active_id] (the same-cycle set rule still wins), set interrupt=0, go to SERV.
  - SERV: interrupt=0. New events keep latching. On eoi, go to IDLE. A new request can be raised on the following edge.
  - Ignored inputs: iack in IDLE or SERV, and eoi in IDLE or REQ.
  - iack and eoi high together are handled per the current state only.
- Latency: src rises and is sampled at posedge k. pending is set after k. interrupt=1 and irq are valid after posedge k+1.
- From eoi at posedge j with eligible work outstanding, interrupt=1 after posedge j+1.
- interrupt and irq are registered outputs with no glitches. irq holds its last value when interrupt=0.
- No nesting: there is exactly one request in flight. This matches the core's single I flag.

Decomposition:
- Package mcu0_intc_pkg holds:
  - the state enum: IDLE, REQ, SERV;
  - register addresses: MASK=0, PEND=1, CLR=2, STAT=3;
  - the STAT field bit positions.
- One sub-module: mcu0_intc_prio, a combinational NSRC-to-3 lowest-index priority encoder with a valid output.
- The state machine, the register file and the capture logic live in the top module.

Test Plan:
- Basic request: write MASK=0x04, pulse src[2] (edge). interrupt=1 and irq=2 two edges later. iack gives interrupt=0 and pending=0. eoi gives STAT state=0.
- Priority: write MASK=0xFF, raise src[5] and src[1] in the same cycle. Expect irq=1. After iack then eoi, expect irq=5 one edge after eoi.
- Mask and withdraw: write MASK=0x08, src[3] is pending and interrupt=1. Write MASK=0 before iack. Expect interrupt=0 the next edge and pending[3] still 1. Restoring MASK re-raises irq=3.
- Set beats clear: in the same cycle a src[4] edge and a CLR write of 0x10. Expect PEND bit 4 reads 1. Separately, an edge on src[4] during SERV is latched and served after eoi.
- Level source (EDGE_MASK=0xFE): hold src[0] high. CLR of bit 0 leaves pending=1. Drop src[0], then CLR, and PEND reads 0. A software PEND write of 0x40 with MASK=0x40 yields irq=6.
- Reset mid-SERV: assert reset asynchronously between edges. Outputs go to 0 immediately. After release, a stray eoi has no effect and STAT reads 0.
